// File: rtl/traffic_pkg.sv
// traffic_pkg: encodings shared by the traffic-light controller, the
// sequence checker and their benches.
//   PAT_*   : raw {red,amber,green} lamp patterns of the four legal phases
//   phase_t : compact phase index, in legal sequence order
//   ERR_*   : first-error cause codes reported by the checker
//   state_t : checker state encoding
package traffic_pkg;

  localparam logic [2:0] PAT_RED       = 3'b100;
  localparam logic [2:0] PAT_RED_AMBER = 3'b110;
  localparam logic [2:0] PAT_GREEN     = 3'b001;
  localparam logic [2:0] PAT_AMBER     = 3'b010;

  typedef enum logic [1:0] {
    PH_RED       = 2'd0,
    PH_RED_AMBER = 2'd1,
    PH_GREEN     = 2'd2,
    PH_AMBER     = 2'd3
  } phase_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_ORDER   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  // Legal successor of a phase: RED -> RED_AMBER -> GREEN -> AMBER -> RED.
  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH_RED:       n = PH_RED_AMBER;
      PH_RED_AMBER: n = PH_GREEN;
      PH_GREEN:     n = PH_AMBER;
      default:      n = PH_RED;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/phase_decoder.sv
// phase_decoder: combinational lamp-pattern decode.
//   red, amber, green : lamp inputs
//   prev_phase        : phase currently being tracked
//   phase             : decoded phase index (PH_RED when illegal)
//   legal             : 1 when the pattern is one of the four legal phases
//   succ              : legal successor of prev_phase
module phase_decoder
  import traffic_pkg::*;
(
  input  logic   red,
  input  logic   amber,
  input  logic   green,
  input  phase_t prev_phase,
  output phase_t phase,
  output logic   legal,
  output phase_t succ
);

  always_comb begin
    phase = PH_RED;
    legal = 1'b1;
    case ({red, amber, green})
      PAT_RED:       phase = PH_RED;
      PAT_RED_AMBER: phase = PH_RED_AMBER;
      PAT_GREEN:     phase = PH_GREEN;
      PAT_AMBER:     phase = PH_AMBER;
      default:       legal = 1'b0;
    endcase
    succ = next_phase(prev_phase);
  end

endmodule

// File: rtl/traffic_light_checker.sv
// traffic_light_checker: monitors traffic-light lamp outputs against the
// legal sequence RED -> RED_AMBER -> GREEN -> AMBER -> RED.
//   clk, rst_n        : clock, synchronous active-low reset
//   red, amber, green : lamp pattern sampled every rising edge
//   clr_err           : clears the error state back to SYNC, keeps the counter
//   locked            : legal phase acquired and no error pending
//   seq_error         : sticky error flag
//   err_code          : first error cause (ERR_* in traffic_pkg)
//   cycle_count       : number of AMBER -> RED transitions, wrapping
//
// state    | meaning
// ST_SYNC  | waiting for the first legal pattern, illegal ones ignored
// ST_TRACK | following the sequence, checking order and dwell time
// ST_ERROR | first fault latched, inputs ignored until clr_err or reset
module traffic_light_checker
  import traffic_pkg::*;
#(
  parameter int MAX_DWELL = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             clr_err,
  output logic             locked,
  output logic             seq_error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW_W = $clog2(MAX_DWELL + 1);
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MAX_DWELL);
  localparam logic [DW_W-1:0] DWELL_ONE = DW_W'(1);

  state_t          state;
  phase_t          prev_phase;
  logic [DW_W-1:0] dwell;

  phase_t cur_phase;
  phase_t succ_phase;
  logic   legal;

  phase_decoder u_phase_decoder (
    .red        (red),
    .amber      (amber),
    .green      (green),
    .prev_phase (prev_phase),
    .phase      (cur_phase),
    .legal      (legal),
    .succ       (succ_phase)
  );

  // ERROR is only entered from TRACK, so err_code always holds the first cause.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_SYNC;
      prev_phase  <= PH_RED;
      dwell       <= '0;
      locked      <= 1'b0;
      seq_error   <= 1'b0;
      err_code    <= ERR_NONE;
      cycle_count <= '0;
    end else if (clr_err) begin
      state     <= ST_SYNC;
      dwell     <= '0;
      locked    <= 1'b0;
      seq_error <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      case (state)
        ST_SYNC: begin
          if (legal) begin
            prev_phase <= cur_phase;
            dwell      <= DWELL_ONE;
            locked     <= 1'b1;
            state      <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (!legal) begin
            state     <= ST_ERROR;
            locked    <= 1'b0;
            seq_error <= 1'b1;
            err_code  <= ERR_ILLEGAL;
          end else if (cur_phase == prev_phase) begin
            // A phase may last exactly MAX_DWELL cycles; one more is a timeout.
            if (dwell == DWELL_MAX) begin
              state     <= ST_ERROR;
              locked    <= 1'b0;
              seq_error <= 1'b1;
              err_code  <= ERR_TIMEOUT;
            end else begin
              dwell <= dwell + DWELL_ONE;
            end
          end else if (cur_phase == succ_phase) begin
            prev_phase <= cur_phase;
            dwell      <= DWELL_ONE;
            if (prev_phase == PH_AMBER) begin
              cycle_count <= cycle_count + CNT_W'(1);
            end
          end else begin
            state     <= ST_ERROR;
            locked    <= 1'b0;
            seq_error <= 1'b1;
            err_code  <= ERR_ORDER;
          end
        end
        ST_ERROR: begin
          locked    <= 1'b0;
          seq_error <= 1'b1;
        end
        default: begin
          state  <= ST_SYNC;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_checker.sv
module tb_traffic_light_checker;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic red = 1'b0;
  logic amber = 1'b0;
  logic green = 1'b0;
  logic clr_err = 1'b0;

  logic       locked8, err8;
  logic [1:0] code8;
  logic [7:0] cnt8;
  logic       locked2, err2;
  logic [1:0] code2;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_light_checker #(.MAX_DWELL(16), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .red(red), .amber(amber), .green(green),
    .clr_err(clr_err), .locked(locked8), .seq_error(err8),
    .err_code(code8), .cycle_count(cnt8)
  );

  traffic_light_checker #(.MAX_DWELL(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .red(red), .amber(amber), .green(green),
    .clr_err(clr_err), .locked(locked2), .seq_error(err2),
    .err_code(code2), .cycle_count(cnt2)
  );

  typedef struct {
    logic       rst_n;
    logic       clr;
    logic [2:0] pat;
    logic       e_locked;
    logic       e_err;
    logic [1:0] e_code;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic c, input logic [2:0] p,
                     input logic l, input logic e, input logic [1:0] code,
                     input logic [7:0] cnt);
    vec_t v;
    v.rst_n = r; v.clr = c; v.pat = p;
    v.e_locked = l; v.e_err = e; v.e_code = code; v.e_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Both DUTs see the same stimulus; the 2-bit counter expects the low bits.
  task automatic chk_all(input string name, input logic l, input logic e,
                         input logic [1:0] code, input logic [7:0] cnt);
    chk({name, ".locked"}, {7'd0, locked8}, {7'd0, l});
    chk({name, ".seq_error"}, {7'd0, err8}, {7'd0, e});
    chk({name, ".err_code"}, {6'd0, code8}, {6'd0, code});
    chk({name, ".cycle_count"}, cnt8, cnt);
    chk({name, ".locked_w2"}, {7'd0, locked2}, {7'd0, l});
    chk({name, ".err_code_w2"}, {6'd0, code2}, {6'd0, code});
    chk({name, ".cycle_count_w2"}, {6'd0, cnt2}, {6'd0, cnt[1:0]});
  endtask

  task automatic step(input logic r, input logic c, input logic [2:0] p);
    rst_n = r;
    clr_err = c;
    {red, amber, green} = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] ill[4];
    ill[0] = 3'b111; ill[1] = 3'b000; ill[2] = 3'b101; ill[3] = 3'b011;

    // Reset, then three full golden sequences ending on RED.
    add(1'b0, 1'b0, PAT_RED, 1'b0, 1'b0, ERR_NONE, 8'd0);
    add(1'b1, 1'b0, PAT_RED, 1'b1, 1'b0, ERR_NONE, 8'd0);
    for (int s = 0; s < 3; s++) begin
      add(1'b1, 1'b0, PAT_RED_AMBER, 1'b1, 1'b0, ERR_NONE, 8'(s));
      add(1'b1, 1'b0, PAT_GREEN,     1'b1, 1'b0, ERR_NONE, 8'(s));
      add(1'b1, 1'b0, PAT_AMBER,     1'b1, 1'b0, ERR_NONE, 8'(s));
      add(1'b1, 1'b0, PAT_RED,       1'b1, 1'b0, ERR_NONE, 8'(s + 1));
    end
    // Illegal pattern, later faults and legal inputs ignored in ERROR.
    add(1'b1, 1'b0, 3'b111,  1'b0, 1'b1, ERR_ILLEGAL, 8'd3);
    add(1'b1, 1'b0, 3'b000,  1'b0, 1'b1, ERR_ILLEGAL, 8'd3);
    add(1'b1, 1'b0, PAT_RED, 1'b0, 1'b1, ERR_ILLEGAL, 8'd3);
    // Clear: inputs on the clear edge are not evaluated.
    add(1'b1, 1'b1, PAT_RED, 1'b0, 1'b0, ERR_NONE, 8'd3);
    add(1'b1, 1'b0, PAT_RED, 1'b1, 1'b0, ERR_NONE, 8'd3);
    // Skip RED -> GREEN.
    add(1'b1, 1'b0, PAT_GREEN, 1'b0, 1'b1, ERR_ORDER, 8'd3);
    add(1'b1, 1'b0, PAT_RED,   1'b0, 1'b1, ERR_ORDER, 8'd3);
    add(1'b1, 1'b1, PAT_RED,   1'b0, 1'b0, ERR_NONE,  8'd3);
    add(1'b1, 1'b0, PAT_RED,   1'b1, 1'b0, ERR_NONE,  8'd3);
    // Clear while tracking, illegal ignored in SYNC, lock on AMBER.
    add(1'b1, 1'b1, 3'b111,    1'b0, 1'b0, ERR_NONE, 8'd3);
    add(1'b1, 1'b0, 3'b000,    1'b0, 1'b0, ERR_NONE, 8'd3);
    add(1'b1, 1'b0, PAT_AMBER, 1'b1, 1'b0, ERR_NONE, 8'd3);
    add(1'b1, 1'b0, PAT_RED,   1'b1, 1'b0, ERR_NONE, 8'd4);
    // Reverse RED -> AMBER, then an illegal pattern must not overwrite.
    add(1'b1, 1'b0, PAT_AMBER, 1'b0, 1'b1, ERR_ORDER, 8'd4);
    add(1'b1, 1'b0, 3'b111,    1'b0, 1'b1, ERR_ORDER, 8'd4);
    add(1'b1, 1'b1, 3'b000,    1'b0, 1'b0, ERR_NONE,  8'd4);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].clr, vecs[i].pat);
      chk_all($sformatf("vec%0d", i), vecs[i].e_locked, vecs[i].e_err,
              vecs[i].e_code, vecs[i].e_cnt);
    end

    // Dwell boundary: 16 GREEN edges legal, 17th is a timeout.
    step(1'b0, 1'b0, PAT_RED);
    step(1'b1, 1'b0, PAT_RED);
    step(1'b1, 1'b0, PAT_RED_AMBER);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, PAT_GREEN);
      chk_all($sformatf("dwell16_%0d", i), 1'b1, 1'b0, ERR_NONE, 8'd0);
    end
    step(1'b1, 1'b0, PAT_AMBER);
    chk_all("dwell16_amber", 1'b1, 1'b0, ERR_NONE, 8'd0);
    step(1'b1, 1'b0, PAT_RED);
    chk_all("dwell16_red", 1'b1, 1'b0, ERR_NONE, 8'd1);
    step(1'b1, 1'b0, PAT_RED_AMBER);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, PAT_GREEN);
      chk_all($sformatf("dwell17_%0d", i), (i != 16), (i == 16),
              (i == 16) ? ERR_TIMEOUT : ERR_NONE, 8'd1);
    end
    step(1'b1, 1'b0, PAT_AMBER);
    chk_all("timeout_sticky", 1'b0, 1'b1, ERR_TIMEOUT, 8'd1);

    // Counter wrap with 5 sequences, then reset mid-GREEN.
    step(1'b0, 1'b0, PAT_RED);
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 1'b0, PAT_RED);
      step(1'b1, 1'b0, PAT_RED_AMBER);
      step(1'b1, 1'b0, PAT_GREEN);
      step(1'b1, 1'b0, PAT_AMBER);
    end
    step(1'b1, 1'b0, PAT_RED);
    chk_all("wrap5", 1'b1, 1'b0, ERR_NONE, 8'd5);
    step(1'b1, 1'b0, PAT_RED_AMBER);
    step(1'b1, 1'b0, PAT_GREEN);
    step(1'b0, 1'b1, PAT_GREEN);
    chk_all("reset_mid", 1'b0, 1'b0, ERR_NONE, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, ill[i]);
      chk_all($sformatf("sync_ignore%0d", i), 1'b0, 1'b0, ERR_NONE, 8'd0);
    end
    step(1'b1, 1'b0, PAT_GREEN);
    chk_all("relock_green", 1'b1, 1'b0, ERR_NONE, 8'd0);
    step(1'b1, 1'b0, PAT_AMBER);
    step(1'b1, 1'b0, PAT_RED);
    chk_all("post_reset_cycle", 1'b1, 1'b0, ERR_NONE, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
